// File: rtl/result_checker.sv
// Scans an output memory against an expected-result memory and reports mismatch/infinity statistics.
// Optional per-word result stream enabled by defining RESULT_STREAM_EN.
module result_checker #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 13,
    parameter int                DEPTH    = 8192,
    parameter int                CNT_W    = 14,
    parameter logic [DATA_W-1:0] INF_CODE = {DATA_W{1'b1}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              neg_cycle,
    input  logic              exp_neg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              neg_detected,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  inf_cnt,
    output logic [ADDR_W-1:0] first_bad_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bad
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONES = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   mism_q, mism_d;
    logic [CNT_W-1:0]   inf_q, inf_d;
    logic [ADDR_W-1:0]  fba_q, fba_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               negdet_q, negdet_d;

    logic               mismatch_s;
    logic               advance_s;
    logic               start_ok_s;
    logic               last_s;

    assign mismatch_s = (rd_data != exp_data);
    assign last_s     = (addr_q == LAST_ADDR);
    assign start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // State and statistics registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= ADDR_ZERO;
            mism_q   <= CNT_ZERO;
            inf_q    <= CNT_ZERO;
            fba_q    <= ADDR_ONES;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            negdet_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mism_q   <= mism_d;
            inf_q    <= inf_d;
            fba_q    <= fba_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            negdet_q <= negdet_d;
        end
    end

    // Next-state logic; abort overrides everything including start
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = neg_cycle ? ST_NEG : ST_SCAN;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_SCAN: begin
                    if (advance_s && last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_NEG:  state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Statistics and result-flag update
    always_comb begin
        addr_d   = addr_q;
        mism_d   = mism_q;
        inf_d    = inf_q;
        fba_d    = fba_q;
        done_d   = done_q;
        pass_d   = pass_q;
        negdet_d = negdet_q;
        if (abort) begin
            done_d = 1'b0;
            pass_d = 1'b0;
        end else if (start_ok_s) begin
            addr_d   = ADDR_ZERO;
            mism_d   = CNT_ZERO;
            inf_d    = CNT_ZERO;
            fba_d    = ADDR_ONES;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            negdet_d = neg_cycle;
        end else if (advance_s) begin
            mism_d = (mismatch_s && (mism_q != CNT_MAX)) ? (mism_q + CNT_W'(1'b1)) : mism_q;
            inf_d  = ((rd_data == INF_CODE) && (inf_q != CNT_MAX)) ? (inf_q + CNT_W'(1'b1)) : inf_q;
            // Counter is still zero only until the first mismatch has been seen
            fba_d  = (mismatch_s && (mism_q == CNT_ZERO)) ? addr_q : fba_q;
            if (last_s) begin
                done_d = 1'b1;
                pass_d = (mism_d == CNT_ZERO) && !exp_neg;
            end else begin
                addr_d = addr_q + ADDR_W'(1'b1);
            end
        end else if (state_q == ST_NEG) begin
            done_d = 1'b1;
            pass_d = exp_neg;
        end else begin
            addr_d = addr_q;
        end
    end

`ifdef RESULT_STREAM_EN
    // Stream outputs; a word advances only when the consumer accepts it
    always_comb begin
        busy      = (state_q == ST_SCAN) || (state_q == ST_NEG);
        out_valid = (state_q == ST_SCAN);
        out_addr  = addr_q;
        out_data  = rd_data;
        out_bad   = mismatch_s;
        advance_s = out_valid && out_ready;
    end
`else
    logic stream_unused_s;
    assign stream_unused_s = out_ready;

    // Stream tied off; scan advances every cycle
    always_comb begin
        busy      = (state_q == ST_SCAN) || (state_q == ST_NEG);
        out_valid = 1'b0;
        out_addr  = ADDR_ZERO;
        out_data  = {DATA_W{1'b0}};
        out_bad   = 1'b0;
        advance_s = (state_q == ST_SCAN);
    end
`endif

    assign rd_addr        = addr_q;
    assign mismatch_cnt   = mism_q;
    assign inf_cnt        = inf_q;
    assign first_bad_addr = fba_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign neg_detected   = negdet_q;

endmodule

// File: tb/tb_result_checker.sv
// Table-driven bench for result_checker (DEPTH=8) with a stats/word scoreboard and a CNT_W=2 twin.
module tb_result_checker;

    logic        clock = 1'b0;
    logic        reset, start, abort, neg_cycle, exp_neg, out_ready;
    logic [2:0]  rd_addr, first_bad_addr, out_addr;
    logic [15:0] rd_data, exp_data, out_data;
    logic        busy, done, pass, neg_detected, out_valid, out_bad;
    logic [13:0] mismatch_cnt, inf_cnt;

    logic [2:0]  s_rd_addr, s_first_bad_addr, s_out_addr;
    logic [15:0] s_rd_data, s_exp_data, s_out_data;
    logic        s_busy, s_done, s_pass, s_neg_detected, s_out_valid, s_out_bad;
    logic [1:0]  s_mismatch_cnt, s_inf_cnt;

    logic [15:0] mem_out [8];
    logic [15:0] mem_exp [8];

    assign rd_data    = mem_out[rd_addr];
    assign exp_data   = mem_exp[rd_addr];
    assign s_rd_data  = mem_out[s_rd_addr];
    assign s_exp_data = mem_exp[s_rd_addr];

    always #5 clock = ~clock;

    result_checker #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .CNT_W(14)) u_dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .neg_cycle(neg_cycle), .exp_neg(exp_neg), .rd_addr(rd_addr),
        .rd_data(rd_data), .exp_data(exp_data), .busy(busy), .done(done),
        .pass(pass), .neg_detected(neg_detected), .mismatch_cnt(mismatch_cnt),
        .inf_cnt(inf_cnt), .first_bad_addr(first_bad_addr), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_bad(out_bad)
    );

    result_checker #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .neg_cycle(neg_cycle), .exp_neg(exp_neg), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .exp_data(s_exp_data), .busy(s_busy), .done(s_done),
        .pass(s_pass), .neg_detected(s_neg_detected), .mismatch_cnt(s_mismatch_cnt),
        .inf_cnt(s_inf_cnt), .first_bad_addr(s_first_bad_addr), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_addr(s_out_addr), .out_data(s_out_data), .out_bad(s_out_bad)
    );

    typedef struct {
        logic [7:0] bad_m;
        logic [7:0] infb_m;
        logic [7:0] info_m;
        logic       neg_c;
        logic       e_neg;
        int         mism;
        int         mism_sat;
        int         infc;
        int         fba;
        int         pass_e;
        int         negd;
    } vec_t;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic        b;
    } word_t;

    vec_t  vecs [8];
    vec_t  sq[$];
    word_t wq[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            mem_exp[i] = 16'(16'h1200 + i * 37);
            mem_out[i] = mem_exp[i];
            if (v.bad_m[i])  mem_out[i] = mem_exp[i] ^ 16'h0010;
            if (v.infb_m[i]) begin mem_out[i] = 16'hFFFF; mem_exp[i] = 16'hFFFF; end
            if (v.info_m[i]) mem_out[i] = 16'hFFFF;
        end
        neg_cycle = v.neg_c;
        exp_neg   = v.e_neg;
    endtask

    task automatic push_words(input int n);
`ifdef RESULT_STREAM_EN
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.a = 3'(i);
            w.d = mem_out[i];
            w.b = (mem_out[i] != mem_exp[i]);
            wq.push_back(w);
        end
`else
        if (n < 0) $display("negative word count %0d", n);
`endif
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    // caller has just passed a negedge; edges counts rising edges since (and including) the start capture
    task automatic wait_done(inout int edges);
        while (!done && edges < 64) begin
            @(posedge clock); edges++;
            @(negedge clock);
        end
    endtask

    task automatic check_stats(input string tag, input int edges, input int lat);
        vec_t e;
        if (sq.size() == 0) begin
            chk({tag, "_sq_empty"}, 1, 0);
        end else begin
            e = sq.pop_front();
            chk({tag, "_latency"}, edges, lat);
            chk({tag, "_done"}, int'(done), 1);
            chk({tag, "_busy"}, int'(busy), 0);
            chk({tag, "_mism"}, int'(mismatch_cnt), e.mism);
            chk({tag, "_mism_sat"}, int'(s_mismatch_cnt), e.mism_sat);
            chk({tag, "_inf"}, int'(inf_cnt), e.infc);
            chk({tag, "_fba"}, int'(first_bad_addr), e.fba);
            chk({tag, "_pass"}, int'(pass), e.pass_e);
            chk({tag, "_negdet"}, int'(neg_detected), e.negd);
        end
    endtask

    task automatic run_vec(input int k);
        int   edges;
        vec_t v;
        v = vecs[k];
        load(v);
        sq.push_back(v);
        if (!v.neg_c) push_words(8);
        pulse_start();
        edges = 1;
        @(negedge clock);
        chk($sformatf("v%0d_busy", k), int'(busy), 1);
        wait_done(edges);
        check_stats($sformatf("v%0d", k), edges, v.neg_c ? 2 : 9);
    endtask

`ifdef RESULT_STREAM_EN
    // Stream scoreboard: compare each accepted word against the queued expectation
    always @(negedge clock) begin : stream_mon
        word_t w;
        if (reset && out_valid && out_ready && !abort) begin
            if (wq.size() == 0) begin
                chk("stream_unexpected_word", int'(out_addr), -1);
            end else begin
                w = wq.pop_front();
                chk("stream_addr", int'(out_addr), int'(w.a));
                chk("stream_data", int'(out_data), int'(w.d));
                chk("stream_bad", int'(out_bad), int'(w.b));
            end
        end
    end
`else
    // Stream ports must stay tied off while scanning
    always @(negedge clock) begin : stream_off_mon
        if (reset && busy)
            chk("stream_tied_off", int'(out_valid | out_bad | (|out_addr) | (|out_data)), 0);
    end
`endif

    initial begin
        int edges;
        int saw_done;
        logic [15:0] held_data;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 0, 0, 7, 1, 0};
        vecs[1] = '{8'h28, 8'h40, 8'h00, 1'b0, 1'b0, 2, 2, 1, 3, 0, 0};
        vecs[2] = '{8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 0, 0, 0, 7, 1, 1};
        vecs[3] = '{8'h97, 8'h00, 8'h00, 1'b0, 1'b0, 5, 3, 0, 0, 0, 0};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0, 0, 0, 7, 0, 0};
        vecs[5] = '{8'h00, 8'h00, 8'h04, 1'b0, 1'b0, 1, 1, 1, 2, 0, 0};
        vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 0, 0, 0, 7, 0, 1};
        vecs[7] = '{8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 0, 0, 8, 7, 1, 0};

        reset = 1'b0; start = 1'b0; abort = 1'b0;
        neg_cycle = 1'b0; exp_neg = 1'b0; out_ready = 1'b1;
        load(vecs[0]);
        #12;
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_mism", int'(mismatch_cnt), 0);
        chk("rst_inf", int'(inf_cnt), 0);
        chk("rst_fba", int'(first_bad_addr), 7);
        chk("rst_flags", int'({busy, done, pass, neg_detected, out_valid}), 0);
        @(posedge clock); #1 reset = 1'b1;
        cycles(1);

        for (int k = 0; k < 8; k++) begin
            run_vec(k);
            if (k == 0) begin
                cycles(3);
                chk("hold_done", int'(done), 1);
                chk("hold_pass", int'(pass), 1);
            end
        end

        // stall: consumer refuses words for three cycles after the first one
        load(vecs[1]);
        sq.push_back(vecs[1]);
        push_words(8);
        pulse_start();
        cycles(1);
        out_ready = 1'b0;
        held_data = out_data;
        cycles(3);
`ifdef RESULT_STREAM_EN
        chk("stall_rd_addr", int'(rd_addr), 1);
        chk("stall_out_data", int'(out_data), int'(held_data));
`else
        chk("nostall_rd_addr", int'(rd_addr), 4);
`endif
        out_ready = 1'b1;
        edges = 5;
        @(negedge clock);
        wait_done(edges);
`ifdef RESULT_STREAM_EN
        check_stats("stall", edges, 12);
`else
        check_stats("stall", edges, 9);
`endif

        // abort at the fourth scan cycle freezes statistics
        load(vecs[0]);
        for (int i = 0; i < 8; i++) if (i == 1 || i == 3 || i == 5) mem_out[i] = mem_exp[i] ^ 16'h0010;
        push_words(3);
        pulse_start();
        cycles(3);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_mism", int'(mismatch_cnt), 1);
        chk("abort_fba", int'(first_bad_addr), 1);
        chk("abort_rd_addr", int'(rd_addr), 3);

        // abort wins over a simultaneous start
        run_vec(0);
        @(posedge clock); #1 abort = 1'b1; start = 1'b1;
        @(posedge clock); #1 abort = 1'b0; start = 1'b0;
        chk("abort_prio_busy", int'(busy), 0);
        chk("abort_prio_done", int'(done), 0);
        chk("abort_prio_pass", int'(pass), 0);

        // reset in the middle of a scan
        load(vecs[3]);
        push_words(2);
        pulse_start();
        cycles(2);
        reset = 1'b0;
        #1;
        chk("midrst_rd_addr", int'(rd_addr), 0);
        chk("midrst_mism", int'(mismatch_cnt), 0);
        chk("midrst_inf", int'(inf_cnt), 0);
        chk("midrst_fba", int'(first_bad_addr), 7);
        chk("midrst_flags", int'({busy, done, pass, neg_detected, out_valid}), 0);
        cycles(2);
        reset = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) saw_done = 1;
        end
        chk("midrst_no_done", saw_done, 0);
        run_vec(1);

        chk("word_queue_drained", wq.size(), 0);
        chk("stat_queue_drained", sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter DATA_W, default 16, meaning width of one output-memory word.
REQ-002 Parameter ADDR_W, default 13, meaning width of the memory address.
REQ-003 Parameter DEPTH, default 8192, meaning number of words scanned, 1..2^ADDR_W.
REQ-004 Parameter CNT_W, default 14, meaning width of the mismatch and infinity counters.
REQ-005 Parameter INF_CODE, default all-ones of DATA_W, meaning the unreachable-distance marker.
REQ-006 Port clock, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1, meaning asynchronous active-low reset.
REQ-008 Port start / abort / neg_cycle / exp_neg, input, 1 each, meaning: solver-finished pulse; cancel scan; solver negative-cycle flag; expected negative-cycle flag.
REQ-009 Port rd_addr, output, ADDR_W, meaning a shared read address to the output memory and the expected-result memory, both asynchronous read.
REQ-010 Port rd_data / exp_data, input, DATA_W each, meaning the output-memory word and the expected word at rd_addr.
REQ-011 Port busy / done / pass / neg_detected, output, 1 each, meaning status flags.
REQ-012 Port mismatch_cnt / inf_cnt, output, CNT_W each, and first_bad_addr, output, ADDR_W, meaning scan statistics.
REQ-013 Port out_valid / out_ready / out_addr / out_data / out_bad, output / input / output ADDR_W / output DATA_W / output 1, meaning the per-word result stream.

Function
REQ-014 The FSM SHALL have the states IDLE, SCAN, NEG and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL clear all statistics, set rd_addr=0, and go to SCAN if neg_cycle=0, or to NEG otherwise.
REQ-016 In SCAN, each cycle SHALL compare rd_data with exp_data at rd_addr; an advance occurs when the stream is disabled or when out_valid and out_ready are both 1.
REQ-017 On advance, a mismatch SHALL increment mismatch_cnt, saturating at 2^CNT_W-1.
REQ-018 On advance, the first mismatch SHALL latch first_bad_addr, which otherwise holds all-ones.
REQ-019 On advance, rd_data==INF_CODE SHALL increment inf_cnt, saturating at 2^CNT_W-1.
REQ-020 INF_CODE in only one of rd_data and exp_data SHALL count as a mismatch.
REQ-021 An advance at rd_addr==DEPTH-1 SHALL go to DONE with rd_addr held; otherwise rd_addr SHALL increment.
REQ-022 The latency from start to done SHALL be DEPTH+1 cycles with out_ready held at 1.
REQ-023 NEG SHALL last one cycle, set neg_detected=1, and go to DONE without scanning.
REQ-024 In DONE, done=1 and pass=(mismatch_cnt==0 and exp_neg==0) after a SCAN, or pass=exp_neg after NEG; done and pass SHALL hold until the next start or reset.
REQ-025 busy SHALL be 1 exactly in SCAN and NEG.
REQ-026 abort=1 in any state SHALL go to IDLE with done=0 and pass=0, leaving statistics frozen; abort SHALL take priority over a simultaneous start.
REQ-027 start while busy SHALL be ignored.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, with rd_addr=0, counters=0, first_bad_addr all-ones, and all flags and out_valid=0.
REQ-029 Reset asserted mid-scan SHALL discard the scan, and no done SHALL follow.

Configuration
REQ-030 With RESULT_STREAM_EN defined, out_valid=1 throughout SCAN, with out_addr=rd_addr, out_data=rd_data and out_bad=mismatch, and the stream SHALL stall on out_ready=0 holding all values stable.
REQ-031 Without RESULT_STREAM_EN, out_valid, out_addr, out_data and out_bad SHALL be constant 0, out_ready SHALL be ignored, and SCAN SHALL advance every cycle.

Verification
REQ-032 DEPTH=8, identical memories, start pulse -> done at cycle 9, pass=1, mismatch_cnt=0, first_bad_addr=7.
REQ-033 Addresses 3 and 5 differ, and address 6 holds FFFF in both memories -> mismatch_cnt=2, first_bad_addr=3, inf_cnt=1, pass=0.
REQ-034 start with neg_cycle=1 and exp_neg=1 -> NEG for one cycle, then done=1, neg_detected=1, pass=1, and rd_data is never compared.
REQ-035 With RESULT_STREAM_EN, out_ready=0 for cycles 2-4 -> rd_addr and out_data are stable, and done arrives at cycle 12.
REQ-036 abort at cycle 4 of a scan -> IDLE with done=0; reset=0 mid-scan -> all outputs cleared immediately; the next start -> a full scan with fresh counts.
REQ-037 With CNT_W=2, five mismatches -> mismatch_cnt saturates at 3.
